riscv_mem_arbiter: RTL and testbench

Two-port to one-port memory arbiter for the multicycle RISC-V core. It shares a single unified memory between the instruction-fetch requester and the load/store requester, with one transaction outstanding at a time. Data accesses have fixed priority, bounded by an anti-starvation counter for fetch. It sits between the core's fetch/LSU stages and the memory macro, which has a fixed read latency.

---
 rtl/riscv_mem_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_riscv_mem_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_mem_arbiter.sv
// -----------------------------------------------------------------------------
// riscv_mem_arbiter
//
// Shares one unified memory macro between the instruction-fetch requester and
// the load/store requester of the multicycle RISC-V core. Only one transaction
// is outstanding at a time. Data accesses win contention unless fetch has lost
// StarveLimit consecutive contended rounds, in which case fetch is forced to win.
//
// Ports
//   clk_i, rst_i             clock, synchronous active-high reset
//   if_req_i / if_addr_i     fetch request and address (held until if_gnt_o)
//   if_gnt_o                 fetch accepted this cycle
//   if_rvalid_o / if_rdata_o fetch response pulse and data (0 when not valid)
//   d_req_i, d_we_i, d_be_i, d_addr_i, d_wdata_i
//                            data request (held until d_gnt_o)
//   d_gnt_o                  data accepted this cycle
//   d_rvalid_o / d_rdata_o   data response pulse (also for stores) and load data
//   mem_req_o .. mem_wdata_o memory request strobe and fields of the winner
//   mem_rdata_i              memory read data, valid MemLatency cycles after req
//   busy_o                   a transaction is outstanding
// -----------------------------------------------------------------------------

package riscv_pkg;
  parameter int XLEN = 32;
endpackage

module riscv_mem_arbiter #(
  parameter int XLEN        = riscv_pkg::XLEN,
  parameter int MemLatency  = 1,
  parameter int StarveLimit = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [XLEN-1:0]   if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [XLEN-1:0]   if_rdata_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [XLEN/8-1:0] d_be_i,
  input  logic [XLEN-1:0]   d_addr_i,
  input  logic [XLEN-1:0]   d_wdata_i,
  output logic              d_gnt_o,
  output logic              d_rvalid_o,
  output logic [XLEN-1:0]   d_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [XLEN/8-1:0] mem_be_o,
  output logic [XLEN-1:0]   mem_addr_o,
  output logic [XLEN-1:0]   mem_wdata_o,
  input  logic [XLEN-1:0]   mem_rdata_i,
  output logic              busy_o
);

  localparam int BeW = XLEN / 8;

  // Countdown start so that rvalid lands exactly MemLatency cycles after grant.
  localparam logic [2:0] LatInit   = 3'(MemLatency - 1);
  localparam logic [3:0] StarveMax = 4'(StarveLimit);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  typedef enum logic [0:0] {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } owner_t;

  state_t     r_state,      w_state_nxt;
  owner_t     r_owner,      w_owner_nxt;
  logic       r_is_write,   w_is_write_nxt;
  logic [2:0] r_lat_cnt,    w_lat_cnt_nxt;
  logic [3:0] r_starve_cnt, w_starve_cnt_nxt;

  logic w_fetch_win;
  logic w_data_win;

  // Arbitration winner among current requests (only acted on in IDLE).
  always_comb begin
    w_fetch_win = if_req_i & (~d_req_i | (r_starve_cnt == StarveMax));
    w_data_win  = d_req_i & ~w_fetch_win;
  end

  // State register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= ST_IDLE;
      r_owner      <= OWN_FETCH;
      r_is_write   <= 1'b0;
      r_lat_cnt    <= 3'd0;
      r_starve_cnt <= 4'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_owner      <= w_owner_nxt;
      r_is_write   <= w_is_write_nxt;
      r_lat_cnt    <= w_lat_cnt_nxt;
      r_starve_cnt <= w_starve_cnt_nxt;
    end
  end

  // Next-state and output decode; reset forces every output low.
  always_comb begin
    w_state_nxt      = r_state;
    w_owner_nxt      = r_owner;
    w_is_write_nxt   = r_is_write;
    w_lat_cnt_nxt    = r_lat_cnt;
    w_starve_cnt_nxt = r_starve_cnt;

    if_gnt_o    = 1'b0;
    if_rvalid_o = 1'b0;
    if_rdata_o  = {XLEN{1'b0}};
    d_gnt_o     = 1'b0;
    d_rvalid_o  = 1'b0;
    d_rdata_o   = {XLEN{1'b0}};
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_be_o    = {BeW{1'b0}};
    mem_addr_o  = {XLEN{1'b0}};
    mem_wdata_o = {XLEN{1'b0}};
    busy_o      = 1'b0;

    if (!rst_i) begin
      case (r_state)
        ST_IDLE: begin
          if (w_fetch_win) begin
            if_gnt_o         = 1'b1;
            mem_req_o        = 1'b1;
            mem_be_o         = {BeW{1'b1}};
            mem_addr_o       = if_addr_i;
            w_state_nxt      = ST_WAIT;
            w_owner_nxt      = OWN_FETCH;
            w_is_write_nxt   = 1'b0;
            w_lat_cnt_nxt    = LatInit;
            w_starve_cnt_nxt = 4'd0;
          end else if (w_data_win) begin
            d_gnt_o        = 1'b1;
            mem_req_o      = 1'b1;
            mem_we_o       = d_we_i;
            // Loads read the whole word; only stores narrow the byte lanes.
            mem_be_o       = d_we_i ? d_be_i : {BeW{1'b1}};
            mem_addr_o     = d_addr_i;
            mem_wdata_o    = d_wdata_i;
            w_state_nxt    = ST_WAIT;
            w_owner_nxt    = OWN_DATA;
            w_is_write_nxt = d_we_i;
            w_lat_cnt_nxt  = LatInit;
            // Fetch lost a contended round: count it, saturating at the limit.
            if (if_req_i && (r_starve_cnt < StarveMax)) begin
              w_starve_cnt_nxt = r_starve_cnt + 4'd1;
            end else begin
              w_starve_cnt_nxt = r_starve_cnt;
            end
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end

        ST_WAIT: begin
          busy_o = 1'b1;
          if (r_lat_cnt == 3'd0) begin
            if (r_owner == OWN_DATA) begin
              d_rvalid_o = 1'b1;
              d_rdata_o  = r_is_write ? {XLEN{1'b0}} : mem_rdata_i;
            end else begin
              if_rvalid_o = 1'b1;
              if_rdata_o  = mem_rdata_i;
            end
            w_state_nxt = ST_IDLE;
          end else begin
            w_lat_cnt_nxt = r_lat_cnt - 3'd1;
          end
        end

        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end else begin
      w_state_nxt = ST_IDLE;
    end
  end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_riscv_mem_arbiter
//
// Main instance (MemLatency=2, StarveLimit=4) is checked every cycle against a
// cycle-index reference model: a grant at cycle T makes the arbiter busy until
// T+ML, the response is due at T+ML, and fetch contention losses are counted.
// A second instance (MemLatency=1) covers back-to-back single-cycle loads.
// -----------------------------------------------------------------------------
module tb_riscv_mem_arbiter;

  localparam int ML = 2;
  localparam int SL = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [3:0]  d_be;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_req, mem_we, busy;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_be;

  // second instance (MemLatency = 1)
  logic        d1_req;
  logic [31:0] d1_addr, d1_mrdata;
  logic        u1_ifg, u1_ifv, u1_dg, u1_dv, u1_mreq, u1_mwe, u1_busy;
  logic [31:0] u1_ifr, u1_dr, u1_maddr, u1_mwdata;
  logic [3:0]  u1_mbe;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // reference model state
  int m_free_at = 0;
  int m_due     = -1;
  int m_losses  = 0;
  bit m_owner_data = 1'b0;
  bit m_write      = 1'b0;
  bit last_ifg, last_dg;

  // values captured at the sample point of the last step
  logic        s_ifg, s_ifv, s_dg, s_dv, s_mreq, s_mwe, s_busy;
  logic [31:0] s_ifr, s_dr, s_maddr, s_mwdata;
  logic [3:0]  s_mbe;
  logic        s1_dg, s1_dv;
  logic [31:0] s1_maddr, s1_dr;

  always #5 clk = ~clk;

  riscv_mem_arbiter #(.XLEN(32), .MemLatency(ML), .StarveLimit(SL)) u_dut (
    .clk_i(clk), .rst_i(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
    .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
    .d_req_i(d_req), .d_we_i(d_we), .d_be_i(d_be), .d_addr_i(d_addr),
    .d_wdata_i(d_wdata), .d_gnt_o(d_gnt), .d_rvalid_o(d_rvalid), .d_rdata_o(d_rdata),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_be_o(mem_be), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .busy_o(busy)
  );

  riscv_mem_arbiter #(.XLEN(32), .MemLatency(1), .StarveLimit(SL)) u_dut1 (
    .clk_i(clk), .rst_i(rst),
    .if_req_i(1'b0), .if_addr_i(32'h0000_0000), .if_gnt_o(u1_ifg),
    .if_rvalid_o(u1_ifv), .if_rdata_o(u1_ifr),
    .d_req_i(d1_req), .d_we_i(1'b0), .d_be_i(4'b0000), .d_addr_i(d1_addr),
    .d_wdata_i(32'h0000_0000), .d_gnt_o(u1_dg), .d_rvalid_o(u1_dv), .d_rdata_o(u1_dr),
    .mem_req_o(u1_mreq), .mem_we_o(u1_mwe), .mem_be_o(u1_mbe), .mem_addr_o(u1_maddr),
    .mem_wdata_o(u1_mwdata), .mem_rdata_i(d1_mrdata), .busy_o(u1_busy)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Evaluate one cycle: sample #1 after the driving negedge, compare against the
  // model, advance the model, and return at the next negedge.
  task automatic step();
    bit          idle, e_ifg, e_dg, e_ifv, e_dv, e_mreq, e_mwe, e_busy;
    logic [31:0] e_ifr, e_dr, e_maddr, e_mwdata;
    logic [3:0]  e_mbe;
    #1;
    s_ifg = if_gnt; s_ifv = if_rvalid; s_ifr = if_rdata;
    s_dg = d_gnt; s_dv = d_rvalid; s_dr = d_rdata;
    s_mreq = mem_req; s_mwe = mem_we; s_mbe = mem_be; s_maddr = mem_addr;
    s_mwdata = mem_wdata; s_busy = busy;
    s1_dg = u1_dg; s1_dv = u1_dv; s1_maddr = u1_maddr; s1_dr = u1_dr;

    e_ifg = 1'b0; e_dg = 1'b0; e_ifv = 1'b0; e_dv = 1'b0; e_mreq = 1'b0;
    e_mwe = 1'b0; e_busy = 1'b0; e_ifr = 32'h0; e_dr = 32'h0; e_maddr = 32'h0;
    e_mwdata = 32'h0; e_mbe = 4'h0;
    if (!rst) begin
      idle   = (cyc >= m_free_at);
      e_ifg  = idle && if_req && (!d_req || (m_losses == SL));
      e_dg   = idle && d_req && !e_ifg;
      e_busy = !idle;
      e_ifv  = !idle && (cyc == m_due) && !m_owner_data;
      e_dv   = !idle && (cyc == m_due) && m_owner_data;
      if (e_ifv) e_ifr = mem_rdata;
      if (e_dv && !m_write) e_dr = mem_rdata;
      if (e_ifg) begin
        e_mreq = 1'b1; e_mbe = 4'hF; e_maddr = if_addr;
      end
      if (e_dg) begin
        e_mreq = 1'b1; e_mwe = d_we; e_mbe = d_we ? d_be : 4'hF;
        e_maddr = d_addr; e_mwdata = d_wdata;
      end
    end

    check_val("if_gnt",    32'(s_ifg),  32'(e_ifg));
    check_val("if_rvalid", 32'(s_ifv),  32'(e_ifv));
    check_val("if_rdata",  s_ifr,       e_ifr);
    check_val("d_gnt",     32'(s_dg),   32'(e_dg));
    check_val("d_rvalid",  32'(s_dv),   32'(e_dv));
    check_val("d_rdata",   s_dr,        e_dr);
    check_val("mem_req",   32'(s_mreq), 32'(e_mreq));
    check_val("mem_we",    32'(s_mwe),  32'(e_mwe));
    check_val("mem_be",    32'(s_mbe),  32'(e_mbe));
    check_val("mem_addr",  s_maddr,     e_maddr);
    check_val("mem_wdata", s_mwdata,    e_mwdata);
    check_val("busy",      32'(s_busy), 32'(e_busy));

    if (rst) begin
      m_free_at = cyc + 1; m_due = -1; m_losses = 0;
    end else if (e_ifg || e_dg) begin
      m_due = cyc + ML; m_free_at = cyc + ML + 1;
      m_owner_data = e_dg; m_write = e_dg && d_we;
      if (e_ifg) m_losses = 0;
      else if (if_req) m_losses = (m_losses < SL) ? m_losses + 1 : SL;
    end
    last_ifg = e_ifg; last_dg = e_dg;
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain(input int n);
    if_req = 1'b0; d_req = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int          g;
    int          idx;
    logic [31:0] rv;
    rst = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_be = 4'h0;
    if_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0; mem_rdata = 32'h0;
    d1_req = 1'b0; d1_addr = 32'h0; d1_mrdata = 32'h0;
    @(negedge clk);
    step(); step();
    rst = 1'b0;
    step();

    // single fetch
    if_req = 1'b1; if_addr = 32'h0000_0100;
    step();
    check_val("t1_gnt", 32'(s_ifg), 32'd1);
    check_val("t1_addr", s_maddr, 32'h0000_0100);
    if_addr = 32'h0000_0104;
    step();
    check_val("t1_nognt_t1", 32'(s_ifg), 32'd0);
    mem_rdata = 32'h0050_0093;
    step();
    check_val("t1_rvalid", 32'(s_ifv), 32'd1);
    check_val("t1_rdata", s_ifr, 32'h0050_0093);
    check_val("t1_nognt_t2", 32'(s_ifg), 32'd0);
    step();
    check_val("t1_regnt_t3", 32'(s_ifg), 32'd1);
    drain(3);

    // store
    d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_addr = 32'h0000_2004; d_wdata = 32'hDEAD_BEEF;
    step();
    check_val("st_gnt", 32'(s_dg), 32'd1);
    check_val("st_we", 32'(s_mwe), 32'd1);
    check_val("st_be", 32'(s_mbe), 32'h3);
    check_val("st_wdata", s_mwdata, 32'hDEAD_BEEF);
    d_req = 1'b0;
    step();
    mem_rdata = 32'h1234_5678;
    step();
    check_val("st_rvalid", 32'(s_dv), 32'd1);
    check_val("st_rdata", s_dr, 32'h0);
    drain(2);

    // data request arriving during a fetch WAIT
    if_req = 1'b1; if_addr = 32'h0000_0200;
    step();
    if_req = 1'b0; d_req = 1'b1; d_we = 1'b0; d_be = 4'h0; d_addr = 32'h0000_0300;
    step();
    check_val("wait_dgnt_t1", 32'(s_dg), 32'd0);
    step();
    check_val("wait_ifv_t2", 32'(s_ifv), 32'd1);
    check_val("wait_dgnt_t2", 32'(s_dg), 32'd0);
    step();
    check_val("wait_dgnt_t3", 32'(s_dg), 32'd1);
    drain(3);

    // reset in WAIT with one cycle of latency left
    if_req = 1'b1; if_addr = 32'h0000_0400;
    step();
    if_req = 1'b0; rst = 1'b1;
    step();
    check_val("rst_busy_in", 32'(s_busy), 32'd0);
    rst = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0500;
    step();
    check_val("rst_no_rvalid", 32'(s_ifv), 32'd0);
    check_val("rst_busy_after", 32'(s_busy), 32'd0);
    check_val("rst_regrant", 32'(s_dg), 32'd1);
    drain(3);

    // contention: fetch wins every fifth grant
    rst = 1'b1; step(); rst = 1'b0;
    if_req = 1'b1; d_req = 1'b1; d_we = 1'b0; if_addr = 32'h0000_0600; d_addr = 32'h0000_0700;
    g = 0;
    for (int k = 0; k < 80 && g < 10; k++) begin
      step();
      if (s_ifg || s_dg) begin
        check_val($sformatf("contend_gnt%0d_isF", g), 32'(s_ifg), 32'((g == 4) || (g == 9)));
        g++;
      end
    end
    check_val("contend_count", 32'(g), 32'd10);
    drain(3);

    // randomized traffic with occasional resets
    for (int k = 0; k < 1500; k++) begin
      rst = ($urandom_range(0, 99) == 0);
      if (!if_req && ($urandom_range(0, 3) != 0)) begin
        if_req = 1'b1; if_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!d_req && ($urandom_range(0, 3) != 0)) begin
        d_req = 1'b1; d_we = 1'($urandom_range(0, 1)); d_be = 4'($urandom);
        d_addr = $urandom & 32'hFFFF_FFFC; d_wdata = $urandom;
      end
      mem_rdata = $urandom;
      step();
      if (last_ifg) if_req = 1'b0;
      if (last_dg) d_req = 1'b0;
    end
    rst = 1'b0;
    drain(4);

    // MemLatency = 1: back-to-back loads at 0x0, 0x4, 0x8
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      d1_req = (idx < 3);
      d1_addr = 32'(idx * 4);
      d1_mrdata = $urandom;
      rv = d1_mrdata;
      step();
      check_val($sformatf("b2b_gnt_c%0d", c), 32'(s1_dg), 32'((c % 2 == 0) && (c < 6)));
      check_val($sformatf("b2b_rv_c%0d", c), 32'(s1_dv), 32'(c % 2 == 1));
      if (c % 2 == 0) begin
        check_val($sformatf("b2b_addr_c%0d", c), s1_maddr, 32'(c * 2));
        idx++;
      end else begin
        check_val($sformatf("b2b_rdata_c%0d", c), s1_dr, rv);
      end
    end
    d1_req = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
